cv32e40p_instr_realigner: RTL and testbench

CV32E40P_INSTR_REALIGNER -- requirements
Module: cv32e40p_instr_realigner

---
 rtl/cv32e40p_instr_realigner.sv | 156 +++++++++++++++
 tb/tb_cv32e40p_instr_realigner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_realigner.sv
// cv32e40p_instr_realigner: splits word-aligned fetch data into 16/32-bit instructions
//
// Configuration macro: CV32E40P_REALIGN_RVC_EN
//   defined   -> full compressed realignment (ALIGNED/MIS32/MIS16/BR_MIS)
//   undefined -> ALIGNED-only 32-bit pass-through
//
// Ports:
//   clk                   core clock, rising edge
//   rst_n                 asynchronous active-low reset
//   fetch_valid_i         prefetch word valid
//   fetch_rdata_i  [31:0] word-aligned fetch data
//   fetch_ready_o         fetch word consumed this cycle
//   instr_valid_o         instruction presented to decode
//   instr_rdata_o  [31:0] instruction (compressed forms zero-extended)
//   instr_pc_o     [31:0] halfword-aligned PC of instr_rdata_o (registered)
//   instr_is_compressed_o instruction is 16-bit
//   instr_ready_i         ID stage accepts the instruction
//   branch_i              synchronous flush/redirect, highest priority
//   branch_addr_i  [31:0] redirect target
module cv32e40p_instr_realigner (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_is_compressed_o,
    input  logic        instr_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    logic [31:0] pc_q, pc_d;

    assign instr_pc_o = pc_q;

`ifdef CV32E40P_REALIGN_RVC_EN
    localparam logic [1:0] ALIGNED = 2'd0;
    localparam logic [1:0] MIS32   = 2'd1;
    localparam logic [1:0] MIS16   = 2'd2;
    localparam logic [1:0] BR_MIS  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        lo_c, hi_c, xfer;
    logic        unused_addr_bit;

    assign unused_addr_bit = branch_addr_i[0];
    assign lo_c = fetch_rdata_i[1:0] != 2'b11;
    assign hi_c = fetch_rdata_i[17:16] != 2'b11;
    assign xfer = instr_valid_o && instr_ready_i;

    always_comb begin
        instr_valid_o         = 1'b0;
        instr_rdata_o         = 32'h0;
        instr_is_compressed_o = 1'b0;
        fetch_ready_o         = 1'b0;
        state_d               = state_q;
        hold_d                = hold_q;
        pc_d                  = pc_q;
        if (branch_i) begin
            fetch_ready_o = 1'b1;
            pc_d          = {branch_addr_i[31:1], 1'b0};
            state_d       = branch_addr_i[1] ? BR_MIS : ALIGNED;
        end else begin
            case (state_q)
                ALIGNED: begin
                    // data outputs are gated so an idle fetch port presents zeros
                    instr_valid_o         = fetch_valid_i;
                    instr_is_compressed_o = fetch_valid_i && lo_c;
                    instr_rdata_o         = !fetch_valid_i ? 32'h0 :
                                            lo_c ? {16'h0, fetch_rdata_i[15:0]} : fetch_rdata_i;
                    fetch_ready_o         = xfer;
                    if (xfer) begin
                        pc_d = pc_q + (lo_c ? 32'd2 : 32'd4);
                        if (lo_c) begin
                            hold_d  = fetch_rdata_i[31:16];
                            state_d = hi_c ? MIS16 : MIS32;
                        end
                    end
                end
                MIS32: begin
                    instr_valid_o = fetch_valid_i;
                    instr_rdata_o = fetch_valid_i ? {fetch_rdata_i[15:0], hold_q} : 32'h0;
                    fetch_ready_o = xfer;
                    if (xfer) begin
                        hold_d  = fetch_rdata_i[31:16];
                        pc_d    = pc_q + 32'd4;
                        state_d = hi_c ? MIS16 : MIS32;
                    end
                end
                MIS16: begin
                    // upper half of the previous word is complete; no fetch needed
                    instr_valid_o         = 1'b1;
                    instr_rdata_o         = {16'h0, hold_q};
                    instr_is_compressed_o = 1'b1;
                    if (xfer) begin
                        pc_d    = pc_q + 32'd2;
                        state_d = ALIGNED;
                    end
                end
                default: begin
                    // BR_MIS: lower halfword precedes the branch target and is dropped
                    if (fetch_valid_i && hi_c) begin
                        instr_valid_o         = 1'b1;
                        instr_rdata_o         = {16'h0, fetch_rdata_i[31:16]};
                        instr_is_compressed_o = 1'b1;
                        fetch_ready_o         = xfer;
                        if (xfer) begin
                            pc_d    = pc_q + 32'd2;
                            state_d = ALIGNED;
                        end
                    end else if (fetch_valid_i) begin
                        fetch_ready_o = 1'b1;
                        hold_d        = fetch_rdata_i[31:16];
                        state_d       = MIS32;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIGNED;
            hold_q  <= 16'h0;
            pc_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pc_q    <= pc_d;
        end
    end
`else
    logic unused_addr_bits;

    assign unused_addr_bits      = ^branch_addr_i[1:0];
    assign instr_valid_o         = fetch_valid_i && !branch_i;
    assign instr_rdata_o         = instr_valid_o ? fetch_rdata_i : 32'h0;
    assign instr_is_compressed_o = 1'b0;
    assign fetch_ready_o         = branch_i || (instr_valid_o && instr_ready_i);
    assign pc_d                  = branch_i ? {branch_addr_i[31:2], 2'b00} :
                                   (instr_valid_o && instr_ready_i) ? pc_q + 32'd4 : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_instr_realigner.sv
// tb_cv32e40p_instr_realigner: directed self-checking bench for the instruction realigner
module tb_cv32e40p_instr_realigner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_compressed_o;
    logic        instr_ready_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    int checks = 0;
    int failures = 0;

    cv32e40p_instr_realigner dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_ready_o         (fetch_ready_o),
        .instr_valid_o         (instr_valid_o),
        .instr_rdata_o         (instr_rdata_o),
        .instr_pc_o            (instr_pc_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .instr_ready_i         (instr_ready_i),
        .branch_i              (branch_i),
        .branch_addr_i         (branch_addr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive inputs, let combinational outputs settle
    task automatic drv(input logic fv, input logic [31:0] d, input logic rdy,
                       input logic br, input logic [31:0] ba);
        fetch_valid_i = fv;
        fetch_rdata_i = d;
        instr_ready_i = rdy;
        branch_i      = br;
        branch_addr_i = ba;
        #1;
    endtask

    task automatic out(input string tag, input logic v, input logic [31:0] d,
                       input logic c, input logic fr, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'h0, instr_valid_o}, {31'h0, v});
        if (v) chk({tag, "_rdata"}, instr_rdata_o, d);
        if (v) chk({tag, "_comp"}, {31'h0, instr_is_compressed_o}, {31'h0, c});
        chk({tag, "_fready"}, {31'h0, fetch_ready_o}, {31'h0, fr});
        chk({tag, "_pc"}, instr_pc_o, pc);
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_rdata", instr_rdata_o, 32'h0);
        chk("rst_comp", {31'h0, instr_is_compressed_o}, 32'h0);
        chk("rst_fready", {31'h0, fetch_ready_o}, 32'h0);
        chk("rst_pc", instr_pc_o, 32'h0);

        // redirect to 0x100, two 32-bit instructions
        drv(1'b1, 32'h00A00093, 1'b1, 1'b1, 32'h100);
        out("br100", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step();
        drv(1'b1, 32'h00A00093, 1'b1, 1'b0, 32'h0);
        out("w0", 1'b1, 32'h00A00093, 1'b0, 1'b1, 32'h100);
        step();
        drv(1'b1, 32'h00B00113, 1'b1, 1'b0, 32'h0);
        out("w1", 1'b1, 32'h00B00113, 1'b0, 1'b1, 32'h104);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        out("idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h108);

`ifdef CV32E40P_REALIGN_RVC_EN
        // two compressed instructions in one word
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        step();
        drv(1'b1, 32'h45014505, 1'b1, 1'b0, 32'h0);
        out("c0", 1'b1, 32'h4505, 1'b1, 1'b1, 32'h200);
        step();
        drv(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        out("c1_mis16", 1'b1, 32'h4501, 1'b1, 1'b0, 32'h202);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        out("c_back", 1'b0, 32'h0, 1'b0, 1'b0, 32'h204);

        // compressed then straddling 32-bit, with a 3-cycle stall in MIS32
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        step();
        drv(1'b1, 32'h00934505, 1'b1, 1'b0, 32'h0);
        out("s0", 1'b1, 32'h4505, 1'b1, 1'b1, 32'h300);
        step();
        drv(1'b1, 32'h450100A0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            out("stall", 1'b1, 32'h00A00093, 1'b0, 1'b0, 32'h302);
            step();
        end
        drv(1'b1, 32'h450100A0, 1'b1, 1'b0, 32'h0);
        out("s1_mis32", 1'b1, 32'h00A00093, 1'b0, 1'b1, 32'h302);
        step();
        drv(1'b1, 32'h12345678, 1'b1, 1'b1, 32'h600);
        out("br_in_mis16", 1'b0, 32'h0, 1'b0, 1'b1, 32'h306);
        step();
        drv(1'b1, 32'h00A00093, 1'b1, 1'b0, 32'h0);
        out("after_br_aligned", 1'b1, 32'h00A00093, 1'b0, 1'b1, 32'h600);
        step();

        // misaligned branch target, uncompressed upper half
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h402);
        step();
        drv(1'b1, 32'h00931234, 1'b1, 1'b0, 32'h0);
        out("brmis_skip", 1'b0, 32'h0, 1'b0, 1'b1, 32'h402);
        step();
        drv(1'b1, 32'h000000A0, 1'b1, 1'b0, 32'h0);
        out("brmis_32", 1'b1, 32'h00A00093, 1'b0, 1'b1, 32'h402);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        out("brmis_tail", 1'b1, 32'h0, 1'b1, 1'b0, 32'h406);

        // misaligned branch target, compressed upper half
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h702);
        step();
        drv(1'b1, 32'h45051234, 1'b1, 1'b0, 32'h0);
        out("brmis_c", 1'b1, 32'h4505, 1'b1, 1'b1, 32'h702);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        out("brmis_c_next", 1'b0, 32'h0, 1'b0, 1'b0, 32'h704);
`else
        // compressed-looking word passes through as 32-bit, with a stall
        drv(1'b1, 32'h45014505, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            out("stall", 1'b1, 32'h45014505, 1'b0, 1'b0, 32'h108);
            step();
        end
        drv(1'b1, 32'h45014505, 1'b1, 1'b0, 32'h0);
        out("pass", 1'b1, 32'h45014505, 1'b0, 1'b1, 32'h108);
        step();
        drv(1'b1, 32'h00A00093, 1'b1, 1'b1, 32'h402);
        out("br_drop", 1'b0, 32'h0, 1'b0, 1'b1, 32'h10C);
        step();
        drv(1'b1, 32'h00A00093, 1'b1, 1'b0, 32'h0);
        out("br_align", 1'b1, 32'h00A00093, 1'b0, 1'b1, 32'h400);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("pc_after", instr_pc_o, 32'h404);
`endif

        // PC wrap
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFC);
        step();
        drv(1'b1, 32'h00A00093, 1'b1, 1'b0, 32'h0);
        out("wrap0", 1'b1, 32'h00A00093, 1'b0, 1'b1, 32'hFFFFFFFC);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc", instr_pc_o, 32'h0);

        // asynchronous reset mid-instruction, then nothing presented
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h500);
        step();
        drv(1'b1, 32'h00930000, 1'b1, 1'b0, 32'h0);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", instr_pc_o, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        out("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
